// File: rtl/ws2812_rx.sv
// WS2812 NRZ stream receiver: classifies high pulses into bits, assembles
// 24-bit GRB pixels MSB-first, and strobes per pixel and per frame (reset gap).
// Optional pass-through of downstream pixels: define WS2812_RX_FORWARD_EN.
module ws2812_rx #(
    parameter int unsigned BIT_THRESH   = 10,
    parameter int unsigned MIN_HIGH     = 2,
    parameter int unsigned MAX_HIGH     = 32,
    parameter int unsigned RESET_CYCLES = 800,
    parameter int unsigned IDX_W        = 8
`ifdef WS2812_RX_FORWARD_EN
    ,
    parameter int unsigned OWN_PIXELS   = 1
`endif
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             DIN,
    output logic [23:0]      PIX_DATA,
    output logic [IDX_W-1:0] PIX_IDX,
    output logic             PIX_VALID,
    output logic             FRAME_END,
    output logic             ERR,
    output logic             BUSY
`ifdef WS2812_RX_FORWARD_EN
    ,
    output logic             DOUT
`endif
);

    localparam int unsigned LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned HIGH_W = $clog2(MAX_HIGH + 1);

    typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH} state_t;

    logic              din_meta_q, din_sync_q;
    state_t            state_q, state_d;
    logic [LOW_W-1:0]  low_cnt_q, low_cnt_d, low_sat;
    logic [HIGH_W-1:0] high_cnt_q, high_cnt_d, high_sat;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [IDX_W-1:0]  pix_cnt_q, pix_cnt_d, pix_cnt_sat;
    logic              bit_seen_q, bit_seen_d;
    logic [23:0]       pix_data_q, pix_data_d;
    logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_end_q, frame_end_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              bit_val;
    logic              own_pix;
`ifdef WS2812_RX_FORWARD_EN
    logic              armed_q, armed_d;
    logic              fwd_en_q, fwd_en_d;
    logic              din_dly_q;
    logic              dout_q, dout_d;
`endif

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            din_meta_q <= 1'b0;
            din_sync_q <= 1'b0;
        end else begin
            din_meta_q <= DIN;
            din_sync_q <= din_meta_q;
        end
    end

    // Saturating increments so the counters never wrap
    assign low_sat     = (low_cnt_q == LOW_W'(RESET_CYCLES)) ? low_cnt_q : low_cnt_q + LOW_W'(1);
    assign high_sat    = (high_cnt_q == HIGH_W'(MAX_HIGH)) ? high_cnt_q : high_cnt_q + HIGH_W'(1);
    assign pix_cnt_sat = (pix_cnt_q == {IDX_W{1'b1}}) ? pix_cnt_q : pix_cnt_q + IDX_W'(1);

`ifdef WS2812_RX_FORWARD_EN
    assign own_pix = 32'(pix_cnt_q) < OWN_PIXELS;
`else
    assign own_pix = 1'b1;
`endif

    // Next-state and output logic of the pulse decoder
    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        high_cnt_d  = high_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pix_cnt_d   = pix_cnt_q;
        bit_seen_d  = bit_seen_q;
        pix_data_d  = pix_data_q;
        pix_idx_d   = pix_idx_q;
        pix_valid_d = 1'b0;
        frame_end_d = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        bit_val     = 1'b0;
`ifdef WS2812_RX_FORWARD_EN
        armed_d     = armed_q;
        fwd_en_d    = fwd_en_q;
        dout_d      = fwd_en_q & din_dly_q;
`endif
        case (state_q)
            ST_SYNC: begin
                if (din_sync_q) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_sat;
                    if (low_sat == LOW_W'(RESET_CYCLES)) state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (din_sync_q) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = HIGH_W'(1);
                    busy_d     = 1'b1;
`ifdef WS2812_RX_FORWARD_EN
                    if (armed_q) fwd_en_d = 1'b1;
`endif
                end else begin
                    low_cnt_d = low_sat;
                    if (low_cnt_q != LOW_W'(RESET_CYCLES) && low_sat == LOW_W'(RESET_CYCLES)) begin
                        if (bit_cnt_q != 5'd0) err_d = 1'b1;
                        else if (bit_seen_q)   frame_end_d = 1'b1;
                        bit_cnt_d  = 5'd0;
                        pix_cnt_d  = '0;
                        bit_seen_d = 1'b0;
                        busy_d     = 1'b0;
`ifdef WS2812_RX_FORWARD_EN
                        armed_d    = 1'b0;
                        fwd_en_d   = 1'b0;
                        dout_d     = 1'b0;
`endif
                    end
                end
            end
            ST_HIGH: begin
                if ((din_sync_q && high_sat == HIGH_W'(MAX_HIGH)) ||
                    (!din_sync_q && high_cnt_q < HIGH_W'(MIN_HIGH))) begin
                    // Stuck-high or glitch: drop the frame and resynchronise
                    state_d    = ST_SYNC;
                    err_d      = 1'b1;
                    low_cnt_d  = '0;
                    high_cnt_d = high_sat;
                    bit_cnt_d  = 5'd0;
                    pix_cnt_d  = '0;
                    bit_seen_d = 1'b0;
                    busy_d     = 1'b0;
`ifdef WS2812_RX_FORWARD_EN
                    armed_d    = 1'b0;
                    fwd_en_d   = 1'b0;
`endif
                end else if (din_sync_q) begin
                    high_cnt_d = high_sat;
                end else begin
                    bit_val    = high_cnt_q > HIGH_W'(BIT_THRESH);
                    bit_seen_d = 1'b1;
                    state_d    = ST_LOW;
                    low_cnt_d  = LOW_W'(1);
                    if (bit_cnt_q == 5'd23) begin
                        pix_data_d  = {shift_q, bit_val};
                        pix_idx_d   = pix_cnt_q;
                        pix_valid_d = own_pix;
                        pix_cnt_d   = pix_cnt_sat;
                        bit_cnt_d   = 5'd0;
`ifdef WS2812_RX_FORWARD_EN
                        if (32'(pix_cnt_q) + 32'd1 >= OWN_PIXELS) armed_d = 1'b1;
`endif
                    end else begin
                        shift_d   = {shift_q[21:0], bit_val};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Decoder state and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_SYNC;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= '0;
            pix_cnt_q   <= '0;
            bit_seen_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_idx_q   <= '0;
            pix_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pix_cnt_q   <= pix_cnt_d;
            bit_seen_q  <= bit_seen_d;
            pix_data_q  <= pix_data_d;
            pix_idx_q   <= pix_idx_d;
            pix_valid_q <= pix_valid_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    // Forwarding path: synced input delayed two cycles, gated to whole pulses
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            armed_q   <= 1'b0;
            fwd_en_q  <= 1'b0;
            din_dly_q <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            fwd_en_q  <= fwd_en_d;
            din_dly_q <= din_sync_q;
            dout_q    <= dout_d;
        end
    end

    assign DOUT = dout_q;
`endif

    assign PIX_DATA  = pix_data_q;
    assign PIX_IDX   = pix_idx_q;
    assign PIX_VALID = pix_valid_q;
    assign FRAME_END = frame_end_q;
    assign ERR       = err_q;
    assign BUSY      = busy_q;

endmodule
